// File: rtl/stream_collect.sv
// stream_collect: gathers COUNT result words into one of two ping-pong banks
// and streams each completed bank out word by word under valid/ready.
// One bank can fill while the other drains; an input arriving while the
// bank it would write still holds an undrained vector is dropped and
// recorded in a sticky overflow flag.
module stream_collect #(
  parameter int BITS  = 8,
  parameter int COUNT = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] c,
  output logic            out_last,
  output logic            overflow
);

  localparam int IDXW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  // Bank bookkeeping state
  logic [1:0]      full_reg, full_next;
  logic            wbank_reg, wbank_next;
  logic            rbank_reg, rbank_next;
  logic [IDXW-1:0] widx_reg, widx_next;
  logic [IDXW-1:0] ridx_reg, ridx_next;
  logic            overflow_reg, overflow_next;

  // Per-edge events
  logic            wr_en;     // store a into the write bank
  logic            wr_done;   // store completes the write bank
  logic            drop;      // input arrived while write bank still occupied
  logic            rd_xfer;   // downstream takes c this edge
  logic            rd_done;   // transfer of the last word releases the read bank
  logic [1:0]      bank_set;
  logic [1:0]      bank_clr;
  logic [BITS-1:0] rd_word [2];

  // Full flags are sampled before the edge, so a bank released on this
  // edge cannot also accept the write arriving on the same edge.
  assign wr_en   = in_valid & ~full_reg[wbank_reg];
  assign drop    = in_valid &  full_reg[wbank_reg];
  assign wr_done = wr_en & (widx_reg == LAST_IDX);
  assign rd_xfer = out_valid & out_ready;
  assign rd_done = rd_xfer & (ridx_reg == LAST_IDX);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [BITS-1:0] mem [COUNT];

      // Data storage: written only, never reset; contents are unobservable
      // until the bank is refilled and marked full.
      always_ff @(posedge clk) begin
        if (wr_en && (wbank_reg == 1'(gi))) begin
          mem[widx_reg] <= a;
        end
      end

      assign rd_word[gi]  = mem[ridx_reg];
      assign bank_set[gi] = wr_done & (wbank_reg == 1'(gi));
      assign bank_clr[gi] = rd_done & (rbank_reg == 1'(gi));
    end
  endgenerate

  // Next-state logic for pointers, full flags and the sticky overflow
  always_comb begin
    full_next     = (full_reg | bank_set) & ~bank_clr;
    wbank_next    = wbank_reg;
    widx_next     = widx_reg;
    rbank_next    = rbank_reg;
    ridx_next     = ridx_reg;
    overflow_next = overflow_reg | drop;

    if (wr_en) begin
      if (wr_done) begin
        widx_next  = '0;
        wbank_next = ~wbank_reg;
      end else begin
        widx_next = widx_reg + 1'b1;
      end
    end

    if (rd_xfer) begin
      if (rd_done) begin
        ridx_next  = '0;
        rbank_next = ~rbank_reg;
      end else begin
        ridx_next = ridx_reg + 1'b1;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_reg     <= '0;
      wbank_reg    <= 1'b0;
      widx_reg     <= '0;
      rbank_reg    <= 1'b0;
      ridx_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      full_reg     <= full_next;
      wbank_reg    <= wbank_next;
      widx_reg     <= widx_next;
      rbank_reg    <= rbank_next;
      ridx_reg     <= ridx_next;
      overflow_reg <= overflow_next;
    end
  end

  // Outputs are decoded purely from registered state
  assign out_valid = full_reg[rbank_reg];
  assign c         = out_valid ? rd_word[rbank_reg] : '0;
  assign out_last  = out_valid & (ridx_reg == LAST_IDX);
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_stream_collect.sv
// tb_stream_collect: table-driven check of stream_collect (BITS=8, COUNT=4)
// plus hand-written reset-mid-operation and continuous-stream sequences.
module tb_stream_collect;

  localparam int BITS  = 8;
  localparam int COUNT = 4;

  logic            clk;
  logic            rstn;
  logic            in_valid;
  logic [BITS-1:0] a;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] c;
  logic            out_last;
  logic            overflow;

  int checks = 0;
  int errors = 0;

  stream_collect #(.BITS(BITS), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: inputs driven for the coming edge, and the outputs
  // expected just before that edge.
  typedef struct {
    logic            iv;
    logic [BITS-1:0] a;
    logic            rdy;
    logic            ev;
    logic [BITS-1:0] ec;
    logic            el;
    logic            eo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic iv, input int av, input logic rdy,
                              input logic ev, input int ec, input logic el,
                              input logic eo);
    vec_t v;
    v.iv = iv; v.a = BITS'(av); v.rdy = rdy;
    v.ev = ev; v.ec = BITS'(ec); v.el = el; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input int step,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int step, input logic ev,
                          input int ec, input logic el, input logic eo);
    chk({tag, ".out_valid"}, step, out_valid, ev);
    chk({tag, ".c"},         step, c,         BITS'(ec));
    chk({tag, ".out_last"},  step, out_last,  el);
    chk({tag, ".overflow"},  step, overflow,  eo);
  endtask

  initial begin
    int got;
    int sent;
    int exp_next;

    rstn = 1'b0; in_valid = 1'b0; a = '0; out_ready = 1'b0;

    // ---------------- vector table ----------------
    // basic: 10,20,30,40 then drain with ready high
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 10*(i+1), 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 1, 10*(i+1), i == 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // backpressure: fill, stall 5 cycles holding 10, then drain
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 10*(i+1), 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 1, 10, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 1, 10*(i+1), i == 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // ping-pong: two vectors back-to-back with ready low, then release
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, i+1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, i+5, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 1, 1, i+1, (i == 3) || (i == 7), 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0));
    // overflow: third vector's first word (9) is dropped
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, i+1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(1, i+5, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 9, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 1, 1, i+1, (i == 3) || (i == 7), 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1));

    // ---------------- reset state ----------------
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_outs("reset_held", 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // ---------------- table ----------------
    foreach (tbl[i]) begin
      chk_outs("table", i, tbl[i].ev, int'(tbl[i].ec), tbl[i].el, tbl[i].eo);
      $display("table step %0d: iv=%0b a=%0d rdy=%0b -> valid=%0b c=%0d last=%0b ovf=%0b",
               i, tbl[i].iv, tbl[i].a, tbl[i].rdy, out_valid, c, out_last, overflow);
      in_valid  = tbl[i].iv;
      a         = tbl[i].a;
      out_ready = tbl[i].rdy;
      @(negedge clk);
    end

    // ---------------- reset mid-operation ----------------
    // Full vector 1..4 in bank 0, drain 2 words while 5,6 land in bank 1.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = BITS'(i+1); out_ready = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; a = BITS'(i+5); out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_outs("middrain", 0, 1, 3, 0, 1);
    #2 rstn = 1'b0;
    #1;
    chk_outs("async_reset", 0, 0, 0, 0, 0);
    $display("reset mid-op: valid=%0b c=%0d ovf=%0b", out_valid, c, overflow);
    @(negedge clk);
    chk_outs("async_reset_edge", 1, 0, 0, 0, 0);
    rstn = 1'b1;

    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        chk("post_reset.c", got, c, BITS'(7 + got));
        chk("post_reset.last", got, out_last, (got == 3) ? 1'b1 : 1'b0);
        $display("post-reset word %0d: c=%0d last=%0b", got, c, out_last);
        got++;
      end
      in_valid  = (cyc < 4);
      a         = BITS'(7 + cyc);
      out_ready = 1'b1;
      @(negedge clk);
    end
    chk("post_reset.count", 0, got, 4);
    chk("post_reset.overflow", 0, overflow, 0);

    // ---------------- continuous stream, 64 words ----------------
    got = 0; sent = 0; exp_next = 1;
    for (int cyc = 0; cyc < 200 && got < 64; cyc++) begin
      if (out_valid) begin
        chk("stream.c", got, c, BITS'(exp_next));
        chk("stream.last", got, out_last, ((exp_next - 1) % COUNT == COUNT - 1) ? 1'b1 : 1'b0);
        $display("stream word %0d: c=%0d last=%0b", got, c, out_last);
        exp_next++;
        got++;
      end
      in_valid  = (sent < 64);
      a         = BITS'(sent + 1);
      out_ready = 1'b1;
      if (sent < 64) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream.count", 0, got, 64);
    chk("stream.overflow", 0, overflow, 0);
    @(negedge clk);
    chk("stream.idle_valid", 0, out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_collect.md
STREAM_COLLECT -- requirements
Module: stream_collect

Interface
REQ-001 SHALL have parameter BITS, default 8, width of each dot-product result word.
REQ-002 SHALL have parameter COUNT, default 4, number of results per output vector (COUNT >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  one-cycle pulse marking a new result on a; driven by the accumulator stage out_valid.
REQ-006 SHALL have port a  input  BITS  result word, sampled when in_valid=1.
REQ-007 SHALL have port out_valid  output  1  c holds a valid word.
REQ-008 SHALL have port out_ready  input  1  downstream accepts c this cycle.
REQ-009 SHALL have port c  output  BITS  output word.
REQ-010 SHALL have port out_last  output  1  c is element COUNT-1 of the current vector.
REQ-011 SHALL have port overflow  output  1  sticky flag: an input was dropped.

Function
REQ-012 SHALL hold two banks (0, 1) of COUNT words each, with per-bank full flag, write bank pointer wbank, write index widx, read bank pointer rbank, read index ridx.
REQ-013 SHALL, on in_valid=1 with bank wbank not full, store a at bank[wbank][widx] and increment widx.
REQ-014 SHALL, when the store hits widx=COUNT-1, set full[wbank], clear widx to 0 and toggle wbank on the same edge.
REQ-015 SHALL, on in_valid=1 while full[wbank]=1 (both banks occupied), discard a, leave all pointers unchanged and set overflow to 1.
REQ-016 SHALL keep overflow at 1 until reset.
REQ-017 SHALL drive out_valid = full[rbank], combinationally from registered state.
REQ-018 SHALL drive c = bank[rbank][ridx] when out_valid=1, else 0.
REQ-019 SHALL drive out_last = out_valid AND (ridx = COUNT-1).
REQ-020 SHALL count a transfer only on posedge with out_valid=1 and out_ready=1; ridx then increments.
REQ-021 SHALL, on transfer with out_last=1, clear full[rbank], clear ridx to 0 and toggle rbank.
REQ-022 SHALL hold c, out_last and ridx stable while out_valid=1 and out_ready=0.
REQ-023 SHALL assert out_valid first on the cycle after the edge that captures the COUNT-th word of a vector; latency is 1 clock.
REQ-024 SHALL apply a simultaneous bank-complete write (REQ-014) and bank-release read (REQ-021) on the same edge, on different banks, both taking effect.
REQ-025 SHALL NOT let a write freed in the same edge be accepted: REQ-015 evaluates the full flags as they stand before the edge.
REQ-026 SHALL emit vectors in arrival order, words in index order 0..COUNT-1.
REQ-027 SHALL ignore a while in_valid=0; values are not checked.
REQ-028 SHALL sustain one input per clock indefinitely if the downstream holds out_ready=1, with no overflow.

Reset
REQ-029 SHALL, while rstn=0 (asynchronously), clear full[0], full[1], wbank, widx, rbank, ridx and overflow.
REQ-030 SHALL, as a result, give out_valid=0, c=0, out_last=0 and overflow=0 during and after reset; a partially collected vector is discarded.
REQ-031 SHALL NOT reset bank data storage; it is unobservable until rewritten.

Verification
REQ-032 SHALL check basic: COUNT=4, inputs 10,20,30,40 on consecutive cycles, out_ready=1 -> out_valid rises the cycle after 40 is captured; c=10,20,30,40 on 4 cycles; out_last only with 40.
REQ-033 SHALL check backpressure: same inputs, out_ready=0 for 5 cycles then 1 -> c holds 10 with out_valid=1 throughout the stall, then 10..40 drain; nothing lost.
REQ-034 SHALL check ping-pong: two vectors 1..4 and 5..8 back-to-back with out_ready=0 -> overflow stays 0; release -> output 1..8 in order; out_last with 4 and with 8.
REQ-035 SHALL check overflow: three vectors 1..4, 5..8, 9 with out_ready=0 -> 9 dropped, overflow=1 from the next cycle, outputs still 1..8, overflow stays 1 after draining.
REQ-036 SHALL check simultaneous events: continuous input stream at 1 per clock with out_ready=1 for 64 words -> all 64 words emitted in order, overflow=0.
REQ-037 SHALL check reset mid-operation: assert rstn=0 after 2 words of a vector and with one full vector mid-drain -> out_valid=0, overflow=0 immediately; after release, a new vector 7,8,9,10 emits exactly 7,8,9,10.
